id_ex_hazard_stage: RTL and testbench

- ID/EX pipeline register combined with load-use and branch-use hazard detection.
- Captures decoded ID-stage operands and control each cycle.
- Drives the EX-stage operand forwarding network (rs/rt tags, register-file data, RegWrite).
- Generates the stall that freezes PC and IF/ID, and inserts a bubble into EX when a hazard is detected.

---
 rtl/id_ex_hazard_stage.sv | 176 +++++++++++++++++
 tb/tb_id_ex_hazard_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use / branch-use hazard detection and bubble insertion.
// Optional stall/bubble performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module id_ex_hazard_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_stall,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rt,
    input  logic [5:0]        id_opcode,
    input  logic [3:0]        id_funct4b,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_data1,
    input  logic [DATA_W-1:0] id_data2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              exmem_memread,
    input  logic [4:0]        exmem_rd,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_data1,
    output logic [DATA_W-1:0] ex_data2,
    output logic [DATA_W-1:0] ex_imm,
    output logic              hazard_stall
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    typedef struct packed {
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic              regwrite;
        logic              memread;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [DATA_W-1:0] imm;
    } ex_t;

    ex_t  ex_q;
    ex_t  ex_d;
    logic branch_use_s;
    logic rt_live_s;
    logic hz_s;
    logic hazard_stall_s;
    logic bubble_s;

    // Register 0 is hard-wired, so it can never be the producer of a hazard.
    function automatic logic src_hit(input logic [4:0] r, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic rt_live);
        return (r != 5'd0) && ((r == rs) || ((r == rt) && rt_live));
    endfunction

    // Decode instructions that resolve in ID and therefore need their sources early.
    always_comb begin
        branch_use_s = 1'b0;
        case (id_opcode)
            6'b000100, 6'b000101: branch_use_s = 1'b1;
            6'b000000:            branch_use_s = (id_funct4b == 4'b1000) || (id_funct4b == 4'b1001);
            default:              branch_use_s = 1'b0;
        endcase
    end

    // Hazard detection against the EX register and the EX/MEM load.
    always_comb begin
        rt_live_s = id_uses_rt | branch_use_s;
        hz_s      = 1'b0;
        if (ex_q.memread && src_hit(ex_q.rd, id_rs, id_rt, rt_live_s)) begin
            hz_s = 1'b1;
        end else if (branch_use_s && ex_q.regwrite && src_hit(ex_q.rd, id_rs, id_rt, rt_live_s)) begin
            hz_s = 1'b1;
        end else if (branch_use_s && exmem_memread && src_hit(exmem_rd, id_rs, id_rt, rt_live_s)) begin
            hz_s = 1'b1;
        end else begin
            hz_s = 1'b0;
        end
        hazard_stall_s = hz_s & ~mem_stall;
        bubble_s       = hz_s & ~mem_stall;
    end

    // Next EX state: freeze, bubble (kill side-effecting fields), or normal capture.
    always_comb begin
        ex_d = ex_q;
        if (mem_stall) begin
            ex_d = ex_q;
        end else begin
            ex_d.rs       = id_rs;
            ex_d.rt       = id_rt;
            ex_d.data1    = id_data1;
            ex_d.data2    = id_data2;
            ex_d.imm      = id_imm;
            if (hz_s) begin
                ex_d.rd       = 5'd0;
                ex_d.regwrite = 1'b0;
                ex_d.memread  = 1'b0;
                ex_d.ctrl     = {CTRL_W{1'b0}};
            end else begin
                ex_d.rd       = id_rd;
                ex_d.regwrite = id_regwrite;
                ex_d.memread  = id_memread;
                ex_d.ctrl     = id_ctrl;
            end
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_rs        = ex_q.rs;
    assign ex_rt        = ex_q.rt;
    assign ex_rd        = ex_q.rd;
    assign ex_regwrite  = ex_q.regwrite;
    assign ex_memread   = ex_q.memread;
    assign ex_ctrl      = ex_q.ctrl;
    assign ex_data1     = ex_q.data1;
    assign ex_data2     = ex_q.data2;
    assign ex_imm       = ex_q.imm;
    assign hazard_stall = hazard_stall_s;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] bubble_cnt_q;
    logic [31:0] bubble_cnt_d;

    // Counter increments; both terms already exclude mem_stall so the counters freeze with the pipe.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (hazard_stall_s) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (bubble_s) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage: expected EX state is queued when an ID instruction
// is driven and compared after the capturing edge.
module tb_id_ex_hazard_stage;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_stall;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic              id_uses_rt;
    logic [5:0]        id_opcode;
    logic [3:0]        id_funct4b;
    logic              id_regwrite, id_memread;
    logic [CTRL_W-1:0] id_ctrl;
    logic [DATA_W-1:0] id_data1, id_data2, id_imm;
    logic              exmem_memread;
    logic [4:0]        exmem_rd;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic              ex_regwrite, ex_memread;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [DATA_W-1:0] ex_data1, ex_data2, ex_imm;
    logic              hazard_stall;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]       stall_cnt, bubble_cnt;
    int unsigned       exp_stall_cnt = 0;
    int unsigned       exp_bubble_cnt = 0;
`endif

    typedef struct packed {
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic              regwrite;
        logic              memread;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [DATA_W-1:0] imm;
    } ex_t;

    ex_t sb_q[$];
    ex_t exp_state;
    int  n_assert = 0;
    int  n_fail   = 0;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    id_ex_hazard_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst_n(rst_n), .mem_stall(mem_stall),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_opcode(id_opcode), .id_funct4b(id_funct4b),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_ctrl(id_ctrl),
        .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm),
        .exmem_memread(exmem_memread), .exmem_rd(exmem_rd),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_ctrl(ex_ctrl),
        .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm),
        .hazard_stall(hazard_stall)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic ex_t observed();
        return '{rs: ex_rs, rt: ex_rt, rd: ex_rd, regwrite: ex_regwrite, memread: ex_memread,
                 ctrl: ex_ctrl, data1: ex_data1, data2: ex_data2, imm: ex_imm};
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One ID instruction for one cycle; exp_hz is the expected hazard_stall before the edge.
    task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic uses_rt, input logic [5:0] op,
                        input logic [3:0] f4, input logic rw, input logic mr,
                        input logic em_mr, input logic [4:0] em_rd,
                        input logic mstall, input logic exp_hz);
        ex_t nxt;
        id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = uses_rt;
        id_opcode = op; id_funct4b = f4; id_regwrite = rw; id_memread = mr;
        id_ctrl = CTRL_W'($urandom); id_data1 = $urandom; id_data2 = $urandom; id_imm = $urandom;
        exmem_memread = em_mr; exmem_rd = em_rd; mem_stall = mstall;
        #1;
        chk({tag, ".stall"}, 160'(hazard_stall), 160'(exp_hz));
        if (!mstall) begin
            nxt = '{rs: rs, rt: rt, rd: rd, regwrite: rw, memread: mr, ctrl: id_ctrl,
                    data1: id_data1, data2: id_data2, imm: id_imm};
            if (exp_hz) begin
                nxt.rd = 5'd0; nxt.regwrite = 1'b0; nxt.memread = 1'b0; nxt.ctrl = '0;
            end
            exp_state = nxt;
        end
`ifdef HAZARD_PERF_CNT_EN
        if (exp_hz) begin
            exp_stall_cnt++;
            exp_bubble_cnt++;
        end
`endif
        sb_q.push_back(exp_state);
        @(posedge clk);
        #1;
        chk({tag, ".ex"}, 160'(observed()), 160'(sb_q.pop_front()));
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, ".scnt"}, 160'(stall_cnt), 160'(exp_stall_cnt));
        chk({tag, ".bcnt"}, 160'(bubble_cnt), 160'(exp_bubble_cnt));
`endif
    endtask

    initial begin
        rst_n = 1'b0; mem_stall = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; id_uses_rt = 1'b0;
        id_opcode = 6'd0; id_funct4b = 4'd0; id_regwrite = 1'b0; id_memread = 1'b0;
        id_ctrl = '0; id_data1 = '0; id_data2 = '0; id_imm = '0;
        exmem_memread = 1'b0; exmem_rd = 5'd0;
        exp_state = '0;
        #2;
        chk("reset.ex", 160'(observed()), 160'd0);
        chk("reset.stall", 160'(hazard_stall), 160'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Load-use: lw $8 then add using $8, one stall then the add enters EX.
        step("lw8",      5'd1,  5'd8,  5'd8,  1'b0, OP_LW,  4'd0,    1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0);
        step("add_lu",   5'd8,  5'd3,  5'd2,  1'b1, OP_R,   4'd0,    1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1);
        step("add_go",   5'd8,  5'd3,  5'd2,  1'b1, OP_R,   4'd0,    1'b1, 1'b0, 1'b1, 5'd8,  1'b0, 1'b0);
        // Branch behind load: two stall cycles.
        step("lw9",      5'd1,  5'd9,  5'd9,  1'b0, OP_LW,  4'd0,    1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0);
        step("beq_ex",   5'd9,  5'd0,  5'd0,  1'b1, OP_BEQ, 4'd0,    1'b0, 1'b0, 1'b0, 5'd2,  1'b0, 1'b1);
        step("beq_mem",  5'd9,  5'd0,  5'd0,  1'b1, OP_BEQ, 4'd0,    1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 1'b1);
        step("beq_go",   5'd9,  5'd0,  5'd0,  1'b1, OP_BEQ, 4'd0,    1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0);
        // Branch behind ALU: jr $10 after add $10; jalr on $0 after a $0 writer never stalls.
        step("add10",    5'd1,  5'd2,  5'd10, 1'b1, OP_R,   4'd0,    1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0);
        step("jr_alu",   5'd10, 5'd0,  5'd0,  1'b0, OP_R,   4'b1000, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1);
        step("jr_go",    5'd10, 5'd0,  5'd0,  1'b0, OP_R,   4'b1000, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0);
        step("add0",     5'd1,  5'd2,  5'd0,  1'b1, OP_R,   4'd0,    1'b1, 1'b0, 1'b0, 5'd10, 1'b0, 1'b0);
        step("jalr_r0",  5'd0,  5'd0,  5'd31, 1'b0, OP_R,   4'b1001, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0);
        // rt only matters when it is really read.
        step("lw8b",     5'd1,  5'd8,  5'd8,  1'b0, OP_LW,  4'd0,    1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0);
        step("addi_rt",  5'd3,  5'd8,  5'd8,  1'b0, OP_ADDI,4'd0,    1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0);
        step("lw8c",     5'd1,  5'd8,  5'd8,  1'b0, OP_LW,  4'd0,    1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0);
        step("add_rt",   5'd3,  5'd8,  5'd4,  1'b1, OP_R,   4'd0,    1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1);
        // mem_stall freezes everything and masks the stall; afterwards one stall then bubble.
        step("lw8d",     5'd1,  5'd8,  5'd8,  1'b0, OP_LW,  4'd0,    1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("mstall", 5'd8, 5'd3, 5'd2,  1'b1, OP_R,   4'd0,    1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0);
        end
        step("rel_stall",5'd8,  5'd3,  5'd2,  1'b1, OP_R,   4'd0,    1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1);
        step("rel_go",   5'd8,  5'd3,  5'd2,  1'b1, OP_R,   4'd0,    1'b1, 1'b0, 1'b1, 5'd8,  1'b0, 1'b0);

        // Asynchronous reset while a load-use stall is active.
        step("lw8e",     5'd1,  5'd8,  5'd8,  1'b0, OP_LW,  4'd0,    1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0);
        id_rs = 5'd8; id_rt = 5'd3; id_rd = 5'd2; id_uses_rt = 1'b1; id_opcode = OP_R;
        id_funct4b = 4'd0; id_regwrite = 1'b1; id_memread = 1'b0;
        #1;
        chk("pre_rst.stall", 160'(hazard_stall), 160'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst.ex", 160'(observed()), 160'd0);
        chk("mid_rst.stall", 160'(hazard_stall), 160'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("mid_rst.scnt", 160'(stall_cnt), 160'd0);
        chk("mid_rst.bcnt", 160'(bubble_cnt), 160'd0);
`endif
        @(posedge clk);
        #1;
        chk("hold_rst.ex", 160'(observed()), 160'd0);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
